// File: rtl/sha3_pkg.sv
// Shared Keccak constants, squeeze FSM states
// and per-variant rate sizes.
package sha3_pkg;

    localparam int STATE_SIZE = 1600;
    localparam int Z_WIDTH    = 64;
    localparam int LANE_COUNT = 25;

    localparam int RATE_SHA3_224 = 18;
    localparam int RATE_SHA3_256 = 17;
    localparam int RATE_SHA3_384 = 13;
    localparam int RATE_SHA3_512 = 9;
    localparam int RATE_SHAKE128 = 21;
    localparam int RATE_SHAKE256 = 17;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        WAIT_PERM
    } sq_state_t;

endpackage

// File: rtl/sha3_lane_select.sv
// 25:1 lane multiplexer over a 1600-bit Keccak state.
// Out-of-range indices yield an all-zero lane.
module sha3_lane_select
    import sha3_pkg::*;
(
    input  logic [0:STATE_SIZE-1] state,
    input  logic [4:0]            idx,
    output logic [0:Z_WIDTH-1]    lane
);

    // Pick lane idx; lane bit z sits at state bit 64*idx+z
    always_comb begin
        lane = '0;
        for (int l = 0; l < LANE_COUNT; l++) begin
            if (idx == 5'(l)) begin
                lane = state[l*Z_WIDTH +: Z_WIDTH];
            end
        end
    end

endmodule

// File: rtl/sha3_squeeze.sv
// Squeeze reader: captures a permuted state and
// streams rate lanes as 64-bit words, asking for
// further permutations when the job exceeds the rate.
module sha3_squeeze
    import sha3_pkg::*;
#(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [0:STATE_SIZE-1] STATE_IN,
    input  logic                  STATE_VALID,
    output logic                  STATE_READY,
    output logic                  PERM_REQ,
    output logic [0:Z_WIDTH-1]    DOUT,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic                  DOUT_LAST
);

    localparam int CW = $clog2(OUT_LANES + 1);

    sq_state_t             state;
    sq_state_t             state_nx;
    logic [4:0]            lane_idx;
    logic [4:0]            lane_idx_nx;
    logic [CW-1:0]         out_cnt;
    logic [CW-1:0]         out_cnt_nx;
    logic [0:STATE_SIZE-1] buffer;
    logic [0:Z_WIDTH-1]    lane;
    logic                  capture;
    logic                  last;
    logic                  rate_end;

    sha3_lane_select u_sel (
        .state (buffer),
        .idx   (lane_idx),
        .lane  (lane)
    );

    assign last     = (out_cnt == CW'(OUT_LANES - 1));
    assign rate_end = (lane_idx == 5'(RATE_LANES - 1));

    // Next-state, counter updates and handshake outputs
    always_comb begin
        state_nx    = state;
        lane_idx_nx = lane_idx;
        out_cnt_nx  = out_cnt;
        capture     = 1'b0;
        STATE_READY = 1'b0;
        PERM_REQ    = 1'b0;
        DOUT_VALID  = 1'b0;
        DOUT_LAST   = 1'b0;
        DOUT        = '0;
        unique case (state)
            IDLE: begin
                STATE_READY = 1'b1;
                if (STATE_VALID) begin
                    capture     = 1'b1;
                    lane_idx_nx = '0;
                    out_cnt_nx  = '0;
                    state_nx    = EMIT;
                end
            end
            EMIT: begin
                DOUT_VALID = 1'b1;
                DOUT       = lane;
                DOUT_LAST  = last;
                if (DOUT_READY) begin
                    if (last) begin
                        out_cnt_nx = '0;
                        state_nx   = IDLE;
                    end else if (rate_end) begin
                        out_cnt_nx = out_cnt + 1'b1;
                        state_nx   = WAIT_PERM;
                    end else begin
                        lane_idx_nx = lane_idx + 5'd1;
                        out_cnt_nx  = out_cnt + 1'b1;
                    end
                end
            end
            WAIT_PERM: begin
                PERM_REQ    = 1'b1;
                STATE_READY = 1'b1;
                if (STATE_VALID) begin
                    capture     = 1'b1;
                    lane_idx_nx = '0;
                    state_nx    = EMIT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counters and captured Keccak state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            lane_idx <= '0;
            out_cnt  <= '0;
            buffer   <= '0;
        end else begin
            state    <= state_nx;
            lane_idx <= lane_idx_nx;
            out_cnt  <= out_cnt_nx;
            if (capture) begin
                buffer <= STATE_IN;
            end
        end
    end

endmodule

// File: tb/tb_sha3_squeeze.sv
// Scoreboard bench for sha3_squeeze across four
// rate/length configurations.
module tb_sha3_squeeze;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:1599] st_in [4];
    logic        sv [4];
    logic        sr [4];
    logic        pr [4];
    logic        dv [4];
    logic        dr [4];
    logic        dl [4];
    logic [0:63] dout [4];

    exp_t sb [4][$];
    exp_t mon_e;
    int   acc [4];
    int   rem [4];
    int   n_vec = 0;
    int   n_err = 0;
    int   a0;

    always #5 clk = ~clk;

    sha3_squeeze #(.RATE_LANES(17), .OUT_LANES(4)) u_256 (
        .CLK(clk), .RST_N(rst_n), .STATE_IN(st_in[0]),
        .STATE_VALID(sv[0]), .STATE_READY(sr[0]), .PERM_REQ(pr[0]),
        .DOUT(dout[0]), .DOUT_VALID(dv[0]), .DOUT_READY(dr[0]),
        .DOUT_LAST(dl[0])
    );

    sha3_squeeze #(.RATE_LANES(21), .OUT_LANES(23)) u_shake (
        .CLK(clk), .RST_N(rst_n), .STATE_IN(st_in[1]),
        .STATE_VALID(sv[1]), .STATE_READY(sr[1]), .PERM_REQ(pr[1]),
        .DOUT(dout[1]), .DOUT_VALID(dv[1]), .DOUT_READY(dr[1]),
        .DOUT_LAST(dl[1])
    );

    sha3_squeeze #(.RATE_LANES(9), .OUT_LANES(9)) u_512 (
        .CLK(clk), .RST_N(rst_n), .STATE_IN(st_in[2]),
        .STATE_VALID(sv[2]), .STATE_READY(sr[2]), .PERM_REQ(pr[2]),
        .DOUT(dout[2]), .DOUT_VALID(dv[2]), .DOUT_READY(dr[2]),
        .DOUT_LAST(dl[2])
    );

    sha3_squeeze #(.RATE_LANES(17), .OUT_LANES(1)) u_one (
        .CLK(clk), .RST_N(rst_n), .STATE_IN(st_in[3]),
        .STATE_VALID(sv[3]), .STATE_READY(sr[3]), .PERM_REQ(pr[3]),
        .DOUT(dout[3]), .DOUT_VALID(dv[3]), .DOUT_READY(dr[3]),
        .DOUT_LAST(dl[3])
    );

    function automatic int rl(int i);
        case (i)
            0: return 17;
            1: return 21;
            2: return 9;
            default: return 17;
        endcase
    endfunction

    function automatic int ol(int i);
        case (i)
            0: return 4;
            1: return 23;
            2: return 9;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] lane_val(int seed, int l);
        if (seed == 0) return 64'h0101010101010101 * 64'(l);
        return (64'(seed) << 40) ^ (64'h9E3779B97F4A7C15 * 64'(l + 1));
    endfunction

    function automatic logic [0:1599] mk_state(int seed);
        logic [0:1599] s;
        logic [63:0]   v;
        for (int l = 0; l < 25; l++) begin
            v = lane_val(seed, l);
            for (int z = 0; z < 64; z++) s[64*l+z] = v[z];
        end
        return s;
    endfunction

    function automatic logic [63:0] to_int(logic [0:63] w);
        logic [63:0] r;
        for (int z = 0; z < 64; z++) r[z] = w[z];
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Compare every presented word against the queue head;
    // pop only on an accepted handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 2 && dv[i])
                    check("perm_req_9x9", 64'(pr[i]), 64'd0);
                if (dv[i] && sb[i].size() == 0) begin
                    check($sformatf("unexpected_word%0d", i),
                          64'(dv[i]), 64'd0);
                end else if (dv[i]) begin
                    mon_e = sb[i][0];
                    check($sformatf("dout%0d", i), to_int(dout[i]), mon_e.d);
                    check($sformatf("last%0d", i), 64'(dl[i]), 64'(mon_e.l));
                    if (dr[i]) begin
                        void'(sb[i].pop_front());
                        acc[i]++;
                    end
                end
            end
        end
    end

    task automatic drive_state(int i, int seed, bit push);
        int n;
        int b;
        b = 0;
        @(posedge clk); #1;
        while (!sr[i] && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (!sr[i]) check("state_ready_timeout", 64'(sr[i]), 64'd1);
        st_in[i] = mk_state(seed);
        sv[i] = 1'b1;
        if (push) begin
            n = (rem[i] < rl(i)) ? rem[i] : rl(i);
            for (int l = 0; l < n; l++)
                sb[i].push_back('{lane_val(seed, l), (rem[i] - l) == 1});
            rem[i] -= n;
        end
        @(posedge clk); #1;
        sv[i] = 1'b0;
    endtask

    task automatic start_job(int i, int seed);
        rem[i] = ol(i);
        drive_state(i, seed, 1'b1);
    endtask

    task automatic drain(int i, string tag);
        int b;
        b = 0;
        while (sb[i].size() != 0 && b < 400) begin
            @(posedge clk);
            b++;
        end
        if (sb[i].size() != 0) check(tag, 64'(sb[i].size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int b;
        int pat[4] = '{1, 0, 0, 1};
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'b0;
            dr[i] = 1'b1;
            st_in[i] = '0;
            acc[i] = 0;
            rem[i] = 0;
        end
        #12;
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", 64'(sr[i]), 64'd1);
            check("rst_perm", 64'(pr[i]), 64'd0);
            check("rst_valid", 64'(dv[i]), 64'd0);
            check("rst_last", 64'(dl[i]), 64'd0);
            check("rst_dout", to_int(dout[i]), 64'd0);
        end
        #3 rst_n = 1'b1;

        // SHA3-256: four words back to back
        a0 = acc[0];
        start_job(0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("sha256_words", 64'(acc[0] - a0), 64'd4);
        check("sha256_ready", 64'(sr[0]), 64'd1);
        check("sha256_valid", 64'(dv[0]), 64'd0);

        // Backpressure 1-0-0-1
        a0 = acc[0];
        start_job(0, 1);
        for (int k = 0; k < 4; k++) begin
            dr[0] = pat[k][0];
            @(posedge clk); #1;
        end
        dr[0] = 1'b1;
        drain(0, "bp_timeout");
        check("bp_words", 64'(acc[0] - a0), 64'd4);

        // Load attempt during EMIT is ignored
        dr[0] = 1'b0;
        start_job(0, 2);
        st_in[0] = mk_state(3);
        sv[0] = 1'b1;
        @(posedge clk); #1;
        sv[0] = 1'b0;
        dr[0] = 1'b1;
        drain(0, "ign_timeout");
        check("ign_ready", 64'(sr[0]), 64'd1);

        // SHAKE128: rate boundary then second state
        a0 = acc[1];
        start_job(1, 4);
        b = 0;
        while (!pr[1] && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        check("shake_perm_req", 64'(pr[1]), 64'd1);
        check("shake_valid_off", 64'(dv[1]), 64'd0);
        check("shake_words1", 64'(acc[1] - a0), 64'd21);
        repeat (3) @(posedge clk);
        #1;
        check("shake_perm_hold", 64'(pr[1]), 64'd1);
        drive_state(1, 5, 1'b1);
        drain(1, "shake_timeout");
        check("shake_words2", 64'(acc[1] - a0), 64'd23);
        check("shake_perm_done", 64'(pr[1]), 64'd0);
        check("shake_ready", 64'(sr[1]), 64'd1);

        // OUT_LANES == RATE_LANES == 9
        a0 = acc[2];
        start_job(2, 6);
        drain(2, "eq_timeout");
        check("eq_words", 64'(acc[2] - a0), 64'd9);
        check("eq_perm", 64'(pr[2]), 64'd0);
        check("eq_ready", 64'(sr[2]), 64'd1);

        // Single-word job
        a0 = acc[3];
        start_job(3, 7);
        drain(3, "one_timeout");
        check("one_words", 64'(acc[3] - a0), 64'd1);

        // Async reset in the middle of EMIT
        dr[0] = 1'b0;
        start_job(0, 8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(dv[0]), 64'd0);
        check("arst_ready", 64'(sr[0]), 64'd1);
        check("arst_last", 64'(dl[0]), 64'd0);
        check("arst_dout", to_int(dout[0]), 64'd0);
        for (int i = 0; i < 4; i++) sb[i].delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        dr[0] = 1'b1;
        a0 = acc[0];
        start_job(0, 9);
        repeat (4) @(posedge clk);
        #1;
        check("arst_words", 64'(acc[0] - a0), 64'd4);
        check("arst_ready2", 64'(sr[0]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
